// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt prioritiser driving CP0 commit, pipeline flush and redirect PC.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        eret_i,
    input  logic        adel_mem_i,
    input  logic        ades_mem_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic        kill_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        int_pending_o
);
    typedef enum logic {IDLE, FLUSH} state_t;
    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);
    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [15:0] eff_status;
    logic [31:0] eff_epc, bad_val;
    logic [4:0]  code;
    logic        int_cond, any_flag, take, bad_upd;
    logic        unused;
    assign unused = ^{cp0_status_i[31:16], cp0_cause_i[31:16], cp0_cause_i[7:0]};
    // WB-stage CP0 writes are forwarded so a same-cycle Status/EPC update is honoured
    assign eff_status = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i[15:0] : cp0_status_i[15:0];
    assign eff_epc    = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : cp0_epc_i;
    assign int_cond   = eff_status[0] && !eff_status[1] && |(cp0_cause_i[15:8] & eff_status[15:8]);
    assign any_flag   = |{adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_mem_i, ades_mem_i, eret_i};
    assign take       = state == IDLE && inst_valid_i && !stall_i && (int_pending_o || any_flag);
    assign code = int_pending_o ? 5'h01 : adel_if_i ? 5'h04 : ri_i ? 5'h0a : ov_i ? 5'h0c :
                  trap_i ? 5'h0d : syscall_i ? 5'h08 : break_i ? 5'h09 : adel_mem_i ? 5'h04 :
                  ades_mem_i ? 5'h05 : 5'h0e;
    assign kill_o   = take && code != 5'h0e;
    assign bad_upd  = code == 5'h04 || code == 5'h05;
    assign bad_val  = (code == 5'h04 && adel_if_i) ? pc_i : mem_addr_i;
    assign flush_o  = state == FLUSH;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            state_nxt = take ? FLUSH : IDLE;
            cnt_nxt   = take ? CNT_INIT : cnt;
        end else begin
            state_nxt = (cnt == 2'd0) ? IDLE : FLUSH;
            cnt_nxt   = (cnt == 2'd0) ? cnt : cnt - 2'd1;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            cnt                 <= '0;
            int_pending_o       <= 1'b0;
            excepttype_o        <= '0;
            current_inst_addr_o <= '0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= '0;
            new_pc_o            <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            int_pending_o <= (state == FLUSH || take) ? 1'b0 : int_cond;
            // one-cycle pulse so CP0 commits exactly once per event
            excepttype_o  <= take ? {27'd0, code} : 32'd0;
            if (take) begin
                current_inst_addr_o <= pc_i;
                is_in_delayslot_o   <= is_in_delayslot_i;
                new_pc_o            <= (code == 5'h0e) ? eff_epc : EXC_VECTOR;
                if (bad_upd) bad_addr_o <= bad_val;
            end
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl; expected CP0 commits are queued at drive time and popped at output.
module tb_exc_ctrl;
    localparam int FC = 3;
    localparam logic [31:0] VEC = 32'hBFC00380;
    typedef struct {logic [31:0] code, pc, bad, npc; logic ds;} exp_t;
    typedef struct {logic [8:0] f; logic [31:0] code; int bsel;} pr_t;
    logic clk = 0, resetn = 0;
    logic inst_valid_i, stall_i, is_in_delayslot_i, adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, eret_i;
    logic adel_mem_i, ades_mem_i, cp0_we_i;
    logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
    logic [4:0] cp0_waddr_i;
    logic kill_o, is_in_delayslot_o, flush_o, int_pending_o;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
    exp_t exp_q[$];
    exp_t e;
    logic [31:0] exp_bad = 0;
    int errors = 0, checks = 0;

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .resetn(resetn), .inst_valid_i(inst_valid_i), .stall_i(stall_i), .pc_i(pc_i),
        .is_in_delayslot_i(is_in_delayslot_i), .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i),
        .trap_i(trap_i), .syscall_i(syscall_i), .break_i(break_i), .eret_i(eret_i),
        .adel_mem_i(adel_mem_i), .ades_mem_i(ades_mem_i), .mem_addr_i(mem_addr_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .kill_o(kill_o), .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .int_pending_o(int_pending_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic clear_in();
        {inst_valid_i, stall_i, is_in_delayslot_i, cp0_we_i} = '0;
        {adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_mem_i, ades_mem_i, eret_i} = '0;
        {pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i} = '0;
        cp0_waddr_i = '0;
    endtask

    task automatic set_flags(input logic [8:0] f);
        {adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_mem_i, ades_mem_i, eret_i} = f;
    endtask

    task automatic drain_flush();
        @(negedge clk) clear_in();
        repeat (FC) @(posedge clk);
    endtask

    task automatic test_reset();
        clear_in();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 checks++;
        if ({kill_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o, new_pc_o, int_pending_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got exc=%h pc=%h bad=%h npc=%h flush=%b kill=%b, required all 0",
                     excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o, flush_o, kill_o);
        end
        @(negedge clk) resetn = 1;
    endtask

    task automatic test_syscall();
        @(negedge clk);
        clear_in();
        inst_valid_i = 1; syscall_i = 1; pc_i = 32'hBFC00100;
        exp_q.push_back('{code: 32'h08, pc: 32'hBFC00100, bad: exp_bad, npc: VEC, ds: 1'b0});
        #1 checks++;
        if (kill_o !== 1'b1) begin errors++; $display("FAIL syscall_kill: got %b, required 1", kill_o); end
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, new_pc_o, flush_o} !== {e.code, e.pc, e.ds, e.bad, e.npc, 1'b1}) begin
            errors++;
            $display("FAIL syscall_event: got exc=%h pc=%h ds=%b bad=%h npc=%h flush=%b, required exc=%h pc=%h ds=%b bad=%h npc=%h flush=1",
                     excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, new_pc_o, flush_o, e.code, e.pc, e.ds, e.bad, e.npc);
        end
        @(negedge clk) clear_in();
        @(posedge clk); #1 checks++;
        if ({excepttype_o, flush_o} !== {32'h0, 1'b1}) begin
            errors++; $display("FAIL syscall_pulse: got exc=%h flush=%b, required exc=0 flush=1", excepttype_o, flush_o);
        end
        repeat (FC - 1) @(posedge clk);
        #1 checks++;
        if (flush_o !== 1'b0) begin errors++; $display("FAIL flush_length: got flush=%b after %0d cycles, required 0", flush_o, FC); end
    endtask

    task automatic test_ades();
        @(negedge clk);
        clear_in();
        inst_valid_i = 1; ades_mem_i = 1; mem_addr_i = 32'h3; pc_i = 32'h80001000; is_in_delayslot_i = 1;
        exp_bad = 32'h3;
        exp_q.push_back('{code: 32'h05, pc: 32'h80001000, bad: exp_bad, npc: VEC, ds: 1'b1});
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, new_pc_o, flush_o} !== {e.code, e.pc, e.ds, e.bad, e.npc, 1'b1}) begin
            errors++;
            $display("FAIL ades_event: got exc=%h pc=%h ds=%b bad=%h npc=%h, required exc=%h pc=%h ds=%b bad=%h npc=%h",
                     excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, new_pc_o, e.code, e.pc, e.ds, e.bad, e.npc);
        end
        drain_flush();
    endtask

    task automatic test_priority();
        pr_t tbl[7] = '{
            '{9'b100000100, 32'h04, 1}, '{9'b011100000, 32'h0a, 0}, '{9'b001101000, 32'h0c, 0},
            '{9'b000110000, 32'h0d, 0}, '{9'b000001100, 32'h09, 0}, '{9'b000000111, 32'h04, 2},
            '{9'b000000011, 32'h05, 2}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_in();
            set_flags(tbl[i].f);
            inst_valid_i = 1; pc_i = 32'h80000400 + 32'(i * 4); mem_addr_i = 32'h00001230 + 32'(i);
            if (tbl[i].bsel == 1) exp_bad = pc_i;
            if (tbl[i].bsel == 2) exp_bad = mem_addr_i;
            exp_q.push_back('{code: tbl[i].code, pc: pc_i, bad: exp_bad, npc: VEC, ds: 1'b0});
            #1 checks++;
            if (kill_o !== 1'b1) begin errors++; $display("FAIL prio_kill[%0d]: got %b, required 1", i, kill_o); end
            @(posedge clk); #1 e = exp_q.pop_front(); checks++;
            if ({excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o, flush_o} !== {e.code, e.pc, e.bad, e.npc, 1'b1}) begin
                errors++;
                $display("FAIL prio_event[%0d]: got exc=%h pc=%h bad=%h npc=%h flush=%b, required exc=%h pc=%h bad=%h npc=%h flush=1",
                         i, excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o, flush_o, e.code, e.pc, e.bad, e.npc);
            end
            drain_flush();
        end
    endtask

    task automatic test_interrupt();
        @(negedge clk);
        clear_in();
        cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
        cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000FF03;
        @(posedge clk); #1 checks++;
        if (int_pending_o !== 1'b0) begin errors++; $display("FAIL int_fwd_exl: got %b, required 0", int_pending_o); end
        @(negedge clk) cp0_we_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 checks++;
            if ({int_pending_o, flush_o} !== 2'b10) begin
                errors++; $display("FAIL int_wait_valid[%0d]: got pending=%b flush=%b, required pending=1 flush=0", i, int_pending_o, flush_o);
            end
        end
        @(negedge clk);
        inst_valid_i = 1; syscall_i = 1; pc_i = 32'h80000800;
        exp_q.push_back('{code: 32'h01, pc: 32'h80000800, bad: exp_bad, npc: VEC, ds: 1'b0});
        #1 checks++;
        if (kill_o !== 1'b1) begin errors++; $display("FAIL int_kill: got %b, required 1", kill_o); end
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o, flush_o, int_pending_o} !== {e.code, e.pc, e.bad, e.npc, 2'b10}) begin
            errors++;
            $display("FAIL int_event: got exc=%h pc=%h bad=%h npc=%h flush=%b pending=%b, required exc=%h pc=%h bad=%h npc=%h flush=1 pending=0",
                     excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o, flush_o, int_pending_o, e.code, e.pc, e.bad, e.npc);
        end
        @(negedge clk) begin inst_valid_i = 0; syscall_i = 0; end
        for (int i = 1; i < FC; i++) begin
            @(posedge clk); #1 checks++;
            if ({int_pending_o, flush_o} !== 2'b01) begin
                errors++; $display("FAIL int_flush_pending[%0d]: got pending=%b flush=%b, required pending=0 flush=1", i, int_pending_o, flush_o);
            end
        end
        drain_flush();
    endtask

    task automatic test_eret();
        @(negedge clk);
        clear_in();
        inst_valid_i = 1; eret_i = 1; pc_i = 32'h80000900; cp0_epc_i = 32'h80002000;
        cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h80003000;
        exp_q.push_back('{code: 32'h0e, pc: 32'h80000900, bad: exp_bad, npc: 32'h80003000, ds: 1'b0});
        #1 checks++;
        if (kill_o !== 1'b0) begin errors++; $display("FAIL eret_kill: got %b, required 0", kill_o); end
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, bad_addr_o, new_pc_o, flush_o} !== {e.code, e.bad, e.npc, 1'b1}) begin
            errors++;
            $display("FAIL eret_event: got exc=%h bad=%h npc=%h flush=%b, required exc=%h bad=%h npc=%h flush=1",
                     excepttype_o, bad_addr_o, new_pc_o, flush_o, e.code, e.bad, e.npc);
        end
        drain_flush();
    endtask

    task automatic test_stall();
        @(negedge clk);
        clear_in();
        inst_valid_i = 1; ri_i = 1; ov_i = 1; stall_i = 1; pc_i = 32'h80000a00;
        for (int i = 0; i < 3; i++) begin
            #1 checks++;
            if (kill_o !== 1'b0) begin errors++; $display("FAIL stall_kill[%0d]: got %b, required 0", i, kill_o); end
            @(posedge clk); #1 checks++;
            if ({flush_o, excepttype_o} !== 33'd0) begin
                errors++; $display("FAIL stall_flush[%0d]: got flush=%b exc=%h, required flush=0 exc=0", i, flush_o, excepttype_o);
            end
            @(negedge clk);
        end
        stall_i = 0;
        exp_q.push_back('{code: 32'h0a, pc: 32'h80000a00, bad: exp_bad, npc: VEC, ds: 1'b0});
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, current_inst_addr_o, new_pc_o, flush_o} !== {e.code, e.pc, e.npc, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got exc=%h pc=%h npc=%h flush=%b, required exc=%h pc=%h npc=%h flush=1",
                     excepttype_o, current_inst_addr_o, new_pc_o, flush_o, e.code, e.pc, e.npc);
        end
        drain_flush();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_in();
        inst_valid_i = 1; syscall_i = 1; pc_i = 32'h80000b00;
        repeat (2) exp_q.push_back('{code: 32'h08, pc: 32'h80000b00, bad: exp_bad, npc: VEC, ds: 1'b0});
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, flush_o} !== {e.code, 1'b1}) begin
            errors++; $display("FAIL b2b_first: got exc=%h flush=%b, required exc=%h flush=1", excepttype_o, flush_o, e.code);
        end
        for (int i = 1; i < FC; i++) begin
            @(posedge clk); #1 checks++;
            if ({excepttype_o, flush_o} !== {32'h0, 1'b1}) begin
                errors++; $display("FAIL b2b_flush[%0d]: got exc=%h flush=%b, required exc=0 flush=1", i, excepttype_o, flush_o);
            end
        end
        @(posedge clk); #1 checks++;
        if ({flush_o, kill_o} !== 2'b01) begin
            errors++; $display("FAIL b2b_gap: got flush=%b kill=%b, required flush=0 kill=1", flush_o, kill_o);
        end
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, current_inst_addr_o, flush_o} !== {e.code, e.pc, 1'b1}) begin
            errors++; $display("FAIL b2b_second: got exc=%h pc=%h flush=%b, required exc=%h pc=%h flush=1",
                               excepttype_o, current_inst_addr_o, flush_o, e.code, e.pc);
        end
        drain_flush();
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        clear_in();
        inst_valid_i = 1; break_i = 1; pc_i = 32'h80000c00; is_in_delayslot_i = 1;
        exp_q.push_back('{code: 32'h09, pc: 32'h80000c00, bad: exp_bad, npc: VEC, ds: 1'b1});
        @(posedge clk); #1 e = exp_q.pop_front(); checks++;
        if ({excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o} !== {e.code, e.pc, e.ds, 1'b1}) begin
            errors++; $display("FAIL brk_event: got exc=%h pc=%h ds=%b flush=%b, required exc=%h pc=%h ds=%b flush=1",
                               excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, e.code, e.pc, e.ds);
        end
        @(negedge clk) clear_in();
        @(posedge clk); #2 resetn = 0;
        #1 checks++;
        if ({kill_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o, new_pc_o, int_pending_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_flush: got exc=%h pc=%h ds=%b bad=%h npc=%h flush=%b, required all 0",
                     excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, new_pc_o, flush_o);
        end
        exp_bad = 0;
        @(negedge clk) resetn = 1;
        @(posedge clk); #1 checks++;
        if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_idle: got flush=%b, required 0", flush_o); end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_ades();
        test_priority();
        test_interrupt();
        test_eret();
        test_stall();
        test_back_to_back();
        test_reset_mid_flush();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
